// File: rtl/tf_mod_mul_pipe.sv
// Pipelined Goldilocks modular multiplier, p = 2^64 - 2^32 + 1.
// Four register stages: operand capture, 128-bit product, folded reduction,
// final canonicalisation. A single clock enable (active-low CEN) freezes everything.
module tf_mod_mul_pipe #(
    parameter int unsigned P_WIDTH = 64,
    parameter int unsigned LAT     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               CEN,
    input  logic               in_valid,
    input  logic [P_WIDTH-1:0] in_data,
    input  logic [P_WIDTH-1:0] tf,
    input  logic               tf_bypass,
    output logic               out_valid,
    output logic [P_WIDTH-1:0] out_data,
    output logic [3:0]         out_idx,
    output logic               out_last
);

    localparam logic [63:0] P_MOD = 64'hFFFF_FFFF_0000_0001;
    localparam logic [63:0] EPS   = 64'h0000_0000_FFFF_FFFF;  // 2^64 mod p

    logic               w_en;
    logic [LAT-1:0]     r_vld;
    logic [63:0]        r_a;
    logic [63:0]        r_b;
    logic [127:0]       r_m;
    logic [63:0]        r_r;
    logic [3:0]         r_cnt;

    logic [127:0]       w_m;
    logic [63:0]        w_lo;
    logic [31:0]        w_b32;
    logic [31:0]        w_c32;
    logic [64:0]        w_t0;
    logic [63:0]        w_t;
    logic [63:0]        w_u;
    logic [64:0]        w_r0;
    logic [63:0]        w_r;
    logic [63:0]        w_red;

    assign w_en      = ~CEN;
    assign out_valid = r_vld[LAT-1];

    // Full-width product of the captured operands.
    assign w_m = {64'd0, r_a} * {64'd0, r_b};

    // Fold the product: 2^96 == -1 and 2^64 == 2^32 - 1 (mod p).
    always_comb begin
        w_lo  = r_m[63:0];
        w_b32 = r_m[95:64];
        w_c32 = r_m[127:96];
        w_t0  = {1'b0, w_lo} - {33'd0, w_c32};
        // A borrow means we wrapped by 2^64, which is worth EPS too much.
        w_t   = w_t0[64] ? (w_t0[63:0] - EPS) : w_t0[63:0];
        w_u   = {w_b32, 32'd0} - {32'd0, w_b32};
        w_r0  = {1'b0, w_t} + {1'b0, w_u};
        // A carry drops 2^64, so add back its residue; cannot carry twice.
        w_r   = w_r0[64] ? (w_r0[63:0] + EPS) : w_r0[63:0];
        // r < 2^64 < 2p, so one conditional subtract is enough.
        w_red = (r_r >= P_MOD) ? (r_r - P_MOD) : r_r;
    end

    // Valid shift register tracks which slots carry real samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else if (w_en) begin
            r_vld <= {r_vld[LAT-2:0], in_valid};
        end
    end

    // Datapath stages 1-3; these may carry don't-care data in bubble slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a <= '0;
            r_b <= '0;
            r_m <= '0;
            r_r <= '0;
        end else if (w_en) begin
            r_a <= in_data;
            r_b <= tf_bypass ? 64'd1 : tf;
            r_m <= w_m;
            r_r <= w_r;
        end
    end

    // Output stage: data and group index only move on a real sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
            r_cnt    <= '0;
        end else if (w_en) begin
            out_last <= r_vld[LAT-2] & (r_cnt == 4'd15);
            if (r_vld[LAT-2]) begin
                out_data <= w_red;
                out_idx  <= r_cnt;
                r_cnt    <= r_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_tf_mod_mul_pipe.sv
// Bench for tf_mod_mul_pipe: scoreboard of golden products plus scenario tasks.
module tb_tf_mod_mul_pipe;

    localparam logic [127:0] P128 = 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        CEN = 1'b0;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic [63:0] tf = '0;
    logic        tf_bypass = 1'b0;
    logic        out_valid;
    logic [63:0] out_data;
    logic [3:0]  out_idx;
    logic        out_last;

    int checks = 0;
    int failures = 0;

    logic [63:0] q_data[$];
    int unsigned q_edge[$];
    int unsigned en_cnt = 0;
    logic        last_en = 1'b0;

    tf_mod_mul_pipe #(.P_WIDTH(64), .LAT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .CEN       (CEN),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .tf        (tf),
        .tf_bypass (tf_bypass),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] gold(input logic [63:0] a, input logic [63:0] b,
                                         input logic byp);
        logic [127:0] prod;
        logic [127:0] rem;
        prod = {64'd0, a} * {64'd0, (byp ? 64'd1 : b)};
        rem  = prod % P128;
        return rem[63:0];
    endfunction

    // Scoreboard push on every accepted sample, tagged with the enabled-edge count.
    always @(posedge clk) begin
        last_en <= rst_n && !CEN;
        if (!rst_n) begin
            q_data.delete();
            q_edge.delete();
        end else if (!CEN) begin
            en_cnt <= en_cnt + 1;
            if (in_valid) begin
                q_data.push_back(gold(in_data, tf, tf_bypass));
                q_edge.push_back(en_cnt);
            end
        end
    end

    // Output monitor: pops on each new valid output, checks holds otherwise.
    logic [63:0] prev_data;
    logic        prev_valid;
    logic [3:0]  prev_idx;
    logic        prev_ok = 1'b0;
    logic [3:0]  exp_idx = '0;
    always @(posedge clk) begin
        logic [63:0] ed;
        int unsigned ee;
        #3;
        if (!rst_n) begin
            exp_idx = '0;
            prev_ok = 1'b0;
        end else begin
            if (last_en && out_valid) begin
                checks++;
                if (q_data.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out_valid: got out_valid=1 data=%h, required no output",
                             out_data);
                end else begin
                    ed = q_data.pop_front();
                    ee = q_edge.pop_front();
                    if (out_data !== ed) begin
                        failures++;
                        $display("FAIL data: got %h, required %h", out_data, ed);
                    end
                    checks++;
                    if (en_cnt - ee != 4) begin
                        failures++;
                        $display("FAIL latency: got %0d, required 4", en_cnt - ee);
                    end
                    checks++;
                    if (out_idx !== exp_idx) begin
                        failures++;
                        $display("FAIL out_idx: got %0d, required %0d", out_idx, exp_idx);
                    end
                    checks++;
                    if (out_last !== (exp_idx == 4'd15)) begin
                        failures++;
                        $display("FAIL out_last: got %b, required %b", out_last, exp_idx == 4'd15);
                    end
                    exp_idx = exp_idx + 4'd1;
                end
            end else if (prev_ok) begin
                checks++;
                if (out_data !== prev_data) begin
                    failures++;
                    $display("FAIL data_hold: got %h, required %h", out_data, prev_data);
                end
                if (!last_en) begin
                    checks++;
                    if (out_valid !== prev_valid || out_idx !== prev_idx) begin
                        failures++;
                        $display("FAIL stall_hold: got valid=%b idx=%0d, required valid=%b idx=%0d",
                                 out_valid, out_idx, prev_valid, prev_idx);
                    end
                end else begin
                    checks++;
                    if (out_last !== 1'b0) begin
                        failures++;
                        $display("FAIL last_idle: got %b, required 0", out_last);
                    end
                end
            end
            prev_data  = out_data;
            prev_valid = out_valid;
            prev_idx   = out_idx;
            prev_ok    = 1'b1;
        end
    end

    task automatic send(input logic [63:0] d, input logic [63:0] t, input logic b);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        tf        = t;
        tf_bypass = b;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid  = 1'b0;
            tf_bypass = 1'b0;
        end
    endtask

    task automatic test_reset();
        int cnt;
        #2 rst_n = 1'b0;
        repeat (4) begin
            @(negedge clk);
            in_valid = ~in_valid;
            in_data  = {$urandom, $urandom};
            tf       = {$urandom, $urandom};
        end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 64'd0 || out_idx !== 4'd0 || out_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got v=%b d=%h i=%0d l=%b, required all zero",
                     out_valid, out_data, out_idx, out_last);
        end
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        send(64'd2, 64'd3, 1'b0);
        cnt = 0;
        while (cnt < 10) begin
            @(negedge clk);
            in_valid = 1'b0;
            cnt++;
            if (out_valid) break;
        end
        checks++;
        if (cnt != 4 || out_data !== 64'd6) begin
            failures++;
            $display("FAIL first_latency: got %0d cycles data=%h, required 4 cycles data=6",
                     cnt, out_data);
        end
        idle(2);
    endtask

    task automatic test_basic();
        send(64'd2, 64'd3, 1'b0);
        send(64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b0);
        send(64'h1_0000_0000, 64'h1_0000_0000, 1'b0);
        idle(3);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'h0000_0000_FFFF_FFFF) begin
            failures++;
            $display("FAIL basic_2p64: got v=%b d=%h, required v=1 d=00000000ffffffff",
                     out_valid, out_data);
        end
        idle(4);
    endtask

    task automatic test_corners();
        send(64'hFFFF_FFFF_0000_0000, 64'd2, 1'b0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        idle(3);
        @(negedge clk);
        checks++;
        if (out_data !== 64'h0000_0000_FFFF_FFFE) begin
            failures++;
            $display("FAIL all_ones: got %h, required 00000000fffffffe", out_data);
        end
        for (int i = 0; i < 10000; i++) begin
            logic [63:0] a;
            logic [63:0] b;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (i % 7 == 0) a = 64'hFFFF_FFFF_0000_0000 + 64'($urandom_range(0, 8));
            if (i % 11 == 0) b = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 8));
            send(a, b, 1'b0);
        end
        idle(6);
    endtask

    task automatic test_bypass();
        send(64'd5, 64'hDEAD_BEEF, 1'b1);
        idle(3);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'd5) begin
            failures++;
            $display("FAIL bypass_5: got v=%b d=%h, required v=1 d=5", out_valid, out_data);
        end
        send(64'hFFFF_FFFF_0000_0004, 64'hDEAD_BEEF, 1'b1);
        idle(3);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 64'd3) begin
            failures++;
            $display("FAIL bypass_noncanon: got v=%b d=%h, required v=1 d=3", out_valid, out_data);
        end
        idle(3);
    endtask

    task automatic test_stall();
        int n;
        int sent;
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        idle(2);
        rst_n = 1'b1;
        n    = 0;
        sent = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (last_en && out_valid) begin
                n++;
                checks++;
                if (out_last !== (n == 16)) begin
                    failures++;
                    $display("FAIL stream_last: output %0d got %b, required %b", n, out_last, n == 16);
                end
                if (n == 17 || n == 20) begin
                    checks++;
                    if (out_idx !== ((n == 17) ? 4'd0 : 4'd3)) begin
                        failures++;
                        $display("FAIL stream_idx: output %0d got %0d, required %0d",
                                 n, out_idx, (n == 17) ? 0 : 3);
                    end
                end
            end
            CEN       = (c >= 9 && c < 12);
            tf_bypass = 1'b0;
            if (!CEN && sent < 20 && c != 4 && c != 14) begin
                in_valid = 1'b1;
                in_data  = 64'(sent + 100);
                tf       = 64'hFFFF_FFFF_0000_0000 - 64'(sent);
                sent++;
            end else begin
                in_valid = 1'b0;
            end
        end
        CEN = 1'b0;
        checks++;
        if (n != 20) begin
            failures++;
            $display("FAIL stream_count: got %0d outputs, required 20", n);
        end
    endtask

    task automatic test_reset_mid();
        int stray;
        send(64'd11, 64'd12, 1'b0);
        send(64'd13, 64'd14, 1'b0);
        send(64'd15, 64'd16, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        idle(2);
        rst_n = 1'b1;
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL mid_reset_stale: got %0d valid cycles, required 0", stray);
        end
        send(64'd7, 64'd9, 1'b0);
        idle(3);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_idx !== 4'd0 || out_data !== 64'd63) begin
            failures++;
            $display("FAIL mid_reset_restart: got v=%b i=%0d d=%h, required v=1 i=0 d=3f",
                     out_valid, out_idx, out_data);
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_bypass();
        test_stall();
        test_reset_mid();
        idle(6);
        checks++;
        if (q_data.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending samples, required 0", q_data.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
